// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage and the ALU it feeds.
package id_ex_operand_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Codes 110 and 111 have no ALU operation behind them.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_forward_sel.sv
// Per-operand forwarding source select: MEM beats WB, x0 is never forwarded.
module forward_sel
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush, MEM/WB forwarding and ALU operand selection.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [N-1:0]     RD1D,
  input  logic [N-1:0]     RD2D,
  input  logic [N-1:0]     ImmExtD,
  input  logic [N-1:0]     PCD,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegWriteD,
  input  logic [N-1:0]     ALUResultM,
  input  logic [REG_W-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [N-1:0]     ResultW,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteW,
  output logic [N-1:0]     a,
  output logic [N-1:0]     b,
  output logic [N-1:0]     WriteDataE,
  output logic [2:0]       ALUControlE,
  output logic [REG_W-1:0] RdE,
  output logic             RegWriteE,
  output logic [N-1:0]     PCE,
  output logic             IllegalOpE
);

  logic [N-1:0]     rd1_e, rd2_e, imm_e, pc_e;
  logic [REG_W-1:0] rs1_e, rs2_e, rd_e;
  logic [2:0]       ctl_e;
  logic             alu_src_e, reg_write_e, illegal_e;
  fwd_sel_t         sel_a, sel_b;
  logic [N-1:0]     fwd_b;

  // Reset and flush both load the all-zero bubble, so they share one branch.
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_e       <= '0;
      pc_e        <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      ctl_e       <= ALU_ADD;
      alu_src_e   <= 1'b0;
      reg_write_e <= 1'b0;
      illegal_e   <= 1'b0;
    end else if (!StallE) begin
      rd1_e       <= RD1D;
      rd2_e       <= RD2D;
      imm_e       <= ImmExtD;
      pc_e        <= PCD;
      rs1_e       <= Rs1D;
      rs2_e       <= Rs2D;
      rd_e        <= RdD;
      ctl_e       <= ALUControlD;
      alu_src_e   <= ALUSrcD;
      reg_write_e <= RegWriteD;
      illegal_e   <= is_illegal_op(ALUControlD);
    end
  end

  forward_sel #(.REG_W(REG_W)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (sel_a)
  );

  forward_sel #(.REG_W(REG_W)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (sel_b)
  );

  always_comb begin
    a = rd1_e;
    unique case (sel_a)
      FWD_MEM: a = ALUResultM;
      FWD_WB:  a = ResultW;
      default: a = rd1_e;
    endcase
  end

  always_comb begin
    fwd_b = rd2_e;
    unique case (sel_b)
      FWD_MEM: fwd_b = ALUResultM;
      FWD_WB:  fwd_b = ResultW;
      default: fwd_b = rd2_e;
    endcase
  end

  assign b           = alu_src_e ? imm_e : fwd_b;
  assign WriteDataE  = fwd_b;
  assign ALUControlE = ctl_e;
  assign RdE         = rd_e;
  assign RegWriteE   = reg_write_e;
  assign PCE         = pc_e;
  assign IllegalOpE  = illegal_e;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: driver predicts each cycle's outputs from a behavioural model, monitor compares.
module tb_id_ex_operand_stage;

  localparam int N  = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, StallE, FlushE;
  logic [N-1:0]  RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [RW-1:0] Rs1D, Rs2D, RdD, RdM, RdW;
  logic [2:0]    ALUControlD;
  logic          ALUSrcD, RegWriteD, RegWriteM, RegWriteW;
  logic [N-1:0]  a, b, WriteDataE, PCE;
  logic [2:0]    ALUControlE;
  logic [RW-1:0] RdE;
  logic          RegWriteE, IllegalOpE;

  id_ex_operand_stage #(.N(N), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .a(a), .b(b), .WriteDataE(WriteDataE), .ALUControlE(ALUControlE),
    .RdE(RdE), .RegWriteE(RegWriteE), .PCE(PCE), .IllegalOpE(IllegalOpE)
  );

  typedef struct {
    logic [N-1:0]  rd1, rd2, imm, pc;
    logic [RW-1:0] rs1, rs2, rd;
    logic [2:0]    ctl;
    logic          src, rw, ill;
  } estate_t;

  typedef struct {
    logic [N-1:0]  a, b, wd, pc;
    logic [RW-1:0] rd;
    logic [2:0]    ctl;
    logic          rw, ill;
  } exp_t;

  estate_t m;
  exp_t    q[$];
  int      checks = 0;
  int      fails  = 0;

  // Value an instruction actually sees for source register rs.
  function automatic logic [N-1:0] fwd(input logic [RW-1:0] rs, input logic [N-1:0] rf);
    if (rs == 0) return rf;
    if (RegWriteM && RdM == rs) return ALUResultM;
    if (RegWriteW && RdW == rs) return ResultW;
    return rf;
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (!rst || FlushE) begin
      m = '{default: '0};
    end else if (!StallE) begin
      m = '{rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD, rs1: Rs1D, rs2: Rs2D,
            rd: RdD, ctl: ALUControlD, src: ALUSrcD, rw: RegWriteD,
            ill: (ALUControlD >= 3'd6)};
    end
    #1;
    e.a   = fwd(m.rs1, m.rd1);
    e.wd  = fwd(m.rs2, m.rd2);
    e.b   = m.src ? m.imm : e.wd;
    e.pc  = m.pc;
    e.rd  = m.rd;
    e.ctl = m.ctl;
    e.rw  = m.rw;
    e.ill = m.ill;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic rand_d();
    RD1D        = $urandom;
    RD2D        = $urandom;
    ImmExtD     = $urandom;
    PCD         = $urandom;
    Rs1D        = RW'($urandom_range(0, 3));
    Rs2D        = RW'($urandom_range(0, 3));
    RdD         = RW'($urandom_range(0, 31));
    ALUControlD = 3'($urandom_range(0, 7));
    ALUSrcD     = 1'($urandom_range(0, 1));
    RegWriteD   = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_mw();
    ALUResultM = $urandom;
    ResultW    = $urandom;
    RdM        = RW'($urandom_range(0, 3));
    RdW        = RW'($urandom_range(0, 3));
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a", a, e.a);
        chk("b", b, e.b);
        chk("WriteDataE", WriteDataE, e.wd);
        chk("PCE", PCE, e.pc);
        chk("RdE", N'(RdE), N'(e.rd));
        chk("ALUControlE", N'(ALUControlE), N'(e.ctl));
        chk("RegWriteE", N'(RegWriteE), N'(e.rw));
        chk("IllegalOpE", N'(IllegalOpE), N'(e.ill));
      end
    end
  end

  initial begin
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    rand_d();
    ALUResultM = '0; ResultW = '0; RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    step(); step();
    rst = 1'b1;

    // plain load
    RD1D = 5; RD2D = 7; ALUSrcD = 1'b0; ALUControlD = 3'b001; Rs1D = 1; Rs2D = 2;
    step();

    // forward priority, held under stall so only M/W change
    Rs1D = 3; step();
    StallE = 1'b1; rand_d();
    RdM = 3; RegWriteM = 1'b1; ALUResultM = 32'h11;
    RdW = 3; RegWriteW = 1'b1; ResultW = 32'h22;
    step();
    RegWriteM = 1'b0; step();
    StallE = 1'b0;

    // x0 never forwarded, immediate on b
    Rs2D = 0; RD2D = 9; ALUSrcD = 1'b1; ImmExtD = 32'hFFFF_FFFC;
    RdM = 0; RegWriteM = 1'b1; ALUResultM = 32'hFF; RegWriteW = 1'b0;
    step();

    // stall holds, flush beats stall
    RegWriteD = 1'b1; RdD = 7; step();
    StallE = 1'b1; rand_d(); step(); rand_d(); step();
    FlushE = 1'b1; step();
    StallE = 1'b0; FlushE = 1'b0;

    // illegal opcode then flush
    ALUControlD = 3'b111; step();
    FlushE = 1'b1; step();
    FlushE = 1'b0;

    // reset during stall/flush, then normal load
    StallE = 1'b1; FlushE = 1'b1; rst = 1'b0; rand_d(); step();
    StallE = 1'b0; FlushE = 1'b0; rst = 1'b1; step();

    for (int i = 0; i < 500; i++) begin
      rand_d();
      rand_mw();
      rst    = ($urandom_range(0, 39) != 0);
      StallE = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      step();
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
